// File: rtl/vga_multi_pkg.sv
// Shared types and mode tables for the multi-mode VGA timing generator.
package vga_multi_pkg;

  localparam int CNT_W_DEF = 11;
  localparam int TW        = 11;

  typedef enum logic [1:0] {
    MODE_640x480  = 2'd0,
    MODE_800x600  = 2'd1,
    MODE_1024x768 = 2'd2
  } mode_e;

  typedef struct packed {
    logic [TW-1:0] visible;
    logic [TW-1:0] front_porch;
    logic [TW-1:0] sync_pulse;
    logic [TW-1:0] full;
    logic          sync_pol;
  } axis_timing_t;

  // sync_pol = 1 means the sync pulse is active-high
  localparam axis_timing_t H_TAB [3] = '{
    '{11'd640,  11'd16, 11'd96,  11'd800,  1'b0},
    '{11'd800,  11'd40, 11'd128, 11'd1056, 1'b1},
    '{11'd1024, 11'd24, 11'd136, 11'd1344, 1'b0}
  };

  localparam axis_timing_t V_TAB [3] = '{
    '{11'd480, 11'd10, 11'd2, 11'd525, 1'b0},
    '{11'd600, 11'd1,  11'd4, 11'd628, 1'b1},
    '{11'd768, 11'd3,  11'd6, 11'd806, 1'b0}
  };

  function automatic axis_timing_t h_timing(input mode_e m);
    case (m)
      MODE_800x600:  return H_TAB[1];
      MODE_1024x768: return H_TAB[2];
      default:       return H_TAB[0];
    endcase
  endfunction

  function automatic axis_timing_t v_timing(input mode_e m);
    case (m)
      MODE_800x600:  return V_TAB[1];
      MODE_1024x768: return V_TAB[2];
      default:       return V_TAB[0];
    endcase
  endfunction

  function automatic logic mode_sync_pol(input mode_e m);
    return (m == MODE_800x600);
  endfunction

endpackage

// File: rtl/vga_timing_multi_axis.sv
// vga_axis_gen: one counting axis (H or V) with registered sync/blank that
// always describe the count value presented on the same cycle.
module vga_axis_gen
  import vga_multi_pkg::*;
#(
  parameter int   CNT_W    = CNT_W_DEF,
  parameter logic SYNC_RST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  axis_timing_t     timing,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             blnk,
  output logic             last
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;
  logic             blnk_q, blnk_d;
  logic [CNT_W-1:0] vis_end, sync_lo, sync_hi, last_val;

  // sync_pol here is the polarity of the mode in effect after this edge,
  // so the first pixel of a new mode already shows the right idle level
  always_comb begin
    vis_end  = CNT_W'(timing.visible);
    sync_lo  = CNT_W'(timing.visible) + CNT_W'(timing.front_porch);
    sync_hi  = sync_lo + CNT_W'(timing.sync_pulse);
    last_val = CNT_W'(timing.full) - CNT_W'(1);
    last     = (count_q == last_val);
    count_d  = count_q;
    if (step) begin
      count_d = last ? '0 : count_q + CNT_W'(1);
    end
    blnk_d = (count_d >= vis_end);
    sync_d = ((count_d >= sync_lo) && (count_d < sync_hi)) ? timing.sync_pol
                                                           : ~timing.sync_pol;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sync_q  <= SYNC_RST;
      blnk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blnk_q  <= blnk_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;
  assign blnk  = blnk_q;

endmodule

// File: rtl/vga_timing_multi.sv
// vga_timing_multi: three-mode VGA timing generator, mode changes land on frame
// boundaries. Define VGA_TIMING_CE_EN to add a ce pixel-enable input.
module vga_timing_multi
  import vga_multi_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_MODE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef VGA_TIMING_CE_EN
  input  logic             ce,
`endif
  input  logic [1:0]       mode_req,
  output logic [1:0]       mode_cur,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start
);

  localparam mode_e RST_MODE = mode_e'(2'(DEFAULT_MODE));
  localparam logic  SYNC_RST = ~mode_sync_pol(RST_MODE);

  mode_e        mode_q, mode_d;
  logic         frame_start_q, frame_start_d;
  logic         pix_en, h_last, v_last, wrap;
  axis_timing_t h_cfg, v_cfg;

`ifdef VGA_TIMING_CE_EN
  assign pix_en = ce;
`else
  assign pix_en = 1'b1;
`endif

  // Geometry follows the current mode; polarity follows the mode after this edge
  always_comb begin
    wrap          = pix_en && h_last && v_last;
    frame_start_d = wrap;
    mode_d        = mode_q;
    if (wrap && (mode_req != 2'd3) && (mode_req != mode_q)) begin
      mode_d = mode_e'(mode_req);
    end
    h_cfg          = h_timing(mode_q);
    h_cfg.sync_pol = mode_sync_pol(mode_d);
    v_cfg          = v_timing(mode_q);
    v_cfg.sync_pol = mode_sync_pol(mode_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= RST_MODE;
      frame_start_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      frame_start_q <= frame_start_d;
    end
  end

  vga_axis_gen #(
    .CNT_W    (CNT_W),
    .SYNC_RST (SYNC_RST)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (pix_en),
    .timing (h_cfg),
    .count  (hcount),
    .sync   (hsync),
    .blnk   (hblnk),
    .last   (h_last)
  );

  vga_axis_gen #(
    .CNT_W    (CNT_W),
    .SYNC_RST (SYNC_RST)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (pix_en && h_last),
    .timing (v_cfg),
    .count  (vcount),
    .sync   (vsync),
    .blnk   (vblnk),
    .last   (v_last)
  );

  assign mode_cur    = mode_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_multi.sv
// Self-checking bench for vga_timing_multi: table-driven frame-boundary vectors,
// randomized mode requests and a mid-frame reset, against a pixel/line model.
module tb_vga_timing_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode_req;
  logic [1:0]  mode_cur;
  logic [10:0] hcount, vcount;
  logic        hsync, vsync, hblnk, vblnk, frame_start;

  int ht  [3] = '{800, 1056, 1344};
  int hv  [3] = '{640, 800, 1024};
  int hfp [3] = '{16, 40, 24};
  int hsp [3] = '{96, 128, 136};
  int vt  [3] = '{525, 628, 806};
  int vv  [3] = '{480, 600, 768};
  int vfp [3] = '{10, 1, 3};
  int vsp [3] = '{2, 4, 6};
  bit pol [3] = '{1'b0, 1'b1, 1'b0};

  int m_mode, m_h, m_v;
  bit m_fs, skipv;
  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int req;
    int vjump;
    int cycles;
    int exp_mode;
  } vec_t;

  vec_t vecs [14];

  vga_timing_multi dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_req    (mode_req),
    .mode_cur    (mode_cur),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .hblnk       (hblnk),
    .vblnk       (vblnk),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic bit exp_sync(input int c, input int vis, input int fp,
                                  input int sp, input bit p);
    return (c >= vis + fp && c < vis + fp + sp) ? p : !p;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      if (n_fails <= 30)
        $display("[TB] FAIL %s: got %0d expected %0d (mode %0d h %0d v %0d t=%0t)",
                 name, act, exp, m_mode, m_h, m_v, $time);
    end
  endtask

  task automatic check_all();
    check_output("hcount", int'(hcount), m_h);
    check_output("vcount", int'(vcount), m_v);
    check_output("mode_cur", int'(mode_cur), m_mode);
    check_output("frame_start", int'(frame_start), int'(m_fs));
    check_output("hblnk", int'(hblnk), int'(m_h >= hv[m_mode]));
    check_output("hsync", int'(hsync),
                 int'(exp_sync(m_h, hv[m_mode], hfp[m_mode], hsp[m_mode], pol[m_mode])));
    if (!skipv) begin
      check_output("vblnk", int'(vblnk), int'(m_v >= vv[m_mode]));
      check_output("vsync", int'(vsync),
                   int'(exp_sync(m_v, vv[m_mode], vfp[m_mode], vsp[m_mode], pol[m_mode])));
    end
  endtask

  task automatic model_reset();
    m_mode = 2;
    m_h    = 0;
    m_v    = 0;
    m_fs   = 1'b0;
    skipv  = 1'b0;
  endtask

  // One pixel clock: advance the model at the edge, compare at the falling edge
  task automatic tick();
    int mt;
    @(posedge clk);
    mt = m_mode;
    if (m_h == ht[mt] - 1 && m_v == vt[mt] - 1) begin
      m_h   = 0;
      m_v   = 0;
      m_fs  = 1'b1;
      skipv = 1'b0;
      if (mode_req != 2'd3) m_mode = int'(mode_req);
    end else begin
      m_fs = 1'b0;
      if (m_h == ht[mt] - 1) begin
        m_h   = 0;
        m_v   = m_v + 1;
        skipv = 1'b0;
      end else begin
        m_h = m_h + 1;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  // Skip ahead in the frame by loading the line counter directly
  task automatic jump_v(input int vj);
    force dut.u_v_axis.count_q = 11'(vj);
    #1;
    release dut.u_v_axis.count_q;
    m_v   = vj;
    skipv = 1'b1;
  endtask

  task automatic apply_stimulus(input int req, input int vjump, input int cycles);
    mode_req = 2'(req);
    if (vjump >= 0) jump_v(vjump);
    repeat (cycles) tick();
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_hcount"}, int'(hcount), 0);
    check_output({tag, "_vcount"}, int'(vcount), 0);
    check_output({tag, "_hsync"}, int'(hsync), 1);
    check_output({tag, "_vsync"}, int'(vsync), 1);
    check_output({tag, "_hblnk"}, int'(hblnk), 0);
    check_output({tag, "_vblnk"}, int'(vblnk), 0);
    check_output({tag, "_fstart"}, int'(frame_start), 0);
    check_output({tag, "_mode"}, int'(mode_cur), 2);
  endtask

  initial begin
    vecs[0]  = '{2, 767, 2700, 2};
    vecs[1]  = '{2, 770, 2700, 2};
    vecs[2]  = '{2, 775, 2700, 2};
    vecs[3]  = '{0, 804, 2700, 0};
    vecs[4]  = '{0, 478, 1700, 0};
    vecs[5]  = '{0, 489, 2500, 0};
    vecs[6]  = '{1, 524, 900,  1};
    vecs[7]  = '{1, 599, 2200, 1};
    vecs[8]  = '{1, 603, 2200, 1};
    vecs[9]  = '{3, 627, 1200, 1};
    vecs[10] = '{2, 627, 1200, 2};
    vecs[11] = '{1, 805, 1400, 1};
    vecs[12] = '{1, 627, 1200, 1};
    vecs[13] = '{0, 627, 1200, 0};

    rst_n    = 1'b1;
    mode_req = 2'd2;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Mode-2 lines around blanking/sync edges, then every mode transition
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].req, vecs[i].vjump, vecs[i].cycles);
      check_output($sformatf("row%0d_mode", i), int'(mode_cur), vecs[i].exp_mode);
    end

    // Random requests changing every cycle across a frame boundary
    for (int k = 0; k < 4; k++) begin
      jump_v(vt[m_mode] - 1);
      for (int c = 0; c < 2 * ht[m_mode]; c++) begin
        mode_req = 2'($urandom_range(0, 3));
        tick();
      end
    end

    // Get into mode 1, then reset at (500,300) with a different request pending
    apply_stimulus(1, vt[m_mode] - 1, ht[m_mode] + 10);
    check_output("pre_reset_mode", int'(mode_cur), 1);
    jump_v(300);
    for (int i = 0; i < 1100 && m_h != 500; i++) tick();
    check_output("pre_reset_h", int'(hcount), 500);
    check_output("pre_reset_v", int'(vcount), 300);
    mode_req = 2'd0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3000) tick();
    check_output("post_reset_mode", int'(mode_cur), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_multi.md
Name: vga_timing_multi

Overview:
- Parametrised successor to the fixed 1024x768 timing constants.
- Generates VGA horizontal/vertical counters, sync and blanking for three runtime-selectable modes.
- Sits between the pixel clock domain root and the draw pipeline; all downstream draw modules consume its outputs.
- Mode changes are applied only at frame boundaries, so no torn frames are produced.

Parameters:
- CNT_W, 11, width of the hcount/vcount outputs; must hold FULL_WIDTH-1 of the largest mode (1343).
- DEFAULT_MODE, 2, mode index loaded at reset (0=640x480, 1=800x600, 2=1024x768).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- mode_req  in  2  requested mode; sampled once per frame
- mode_cur  out  2  mode currently in effect
- hcount  out  CNT_W  horizontal pixel index
- vcount  out  CNT_W  vertical line index
- hsync  out  1  horizontal sync, at the mode's polarity
- vsync  out  1  vertical sync, at the mode's polarity
- hblnk  out  1  high outside the visible width
- vblnk  out  1  high outside the visible height
- frame_start  out  1  one-cycle pulse at the first pixel of each new frame

Behaviour:
- Mode table (visible / front porch / sync / total; polarity):
  - Mode 0: H 640/16/96/800, V 480/10/2/525; both sync active-low.
  - Mode 1: H 800/40/128/1056, V 600/1/4/628; both sync active-high.
  - Mode 2: H 1024/24/136/1344, V 768/3/6/806; both sync active-low.
- Reset (async assert, sync release):
  - hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0.
  - mode_cur=DEFAULT_MODE; hsync/vsync at the inactive level of DEFAULT_MODE.
- Counting, every clk:
  - hcount increments.
  - At HT-1, hcount wraps to 0 and vcount increments.
  - At hcount=HT-1 with vcount=VT-1, both counters wrap to 0.
- All outputs are registered and coherent. hsync, vsync, hblnk and vblnk always describe the hcount/vcount value output on the same cycle, so there is zero skew between them.
- hblnk = (hcount >= HV). vblnk = (vcount >= VV).
- hsync is active when HV+HFP <= hcount <= HV+HFP+HSP-1. vsync uses the same rule on the vertical parameters.
- Mode switch:
  - mode_req is sampled only on the cycle the counters are at (HT-1, VT-1).
  - If it differs from mode_cur and is valid (0..2), mode_cur updates together with the wrap to (0,0).
  - The first pixel of the next frame uses the new timing.
  - mode_req=3 is ignored; the current mode is retained.
  - mode_req changes at any other time have no effect.
- frame_start:
  - High for exactly the cycle where outputs show (0,0) after a wrap.
  - Not asserted on the first (0,0) following reset release.
- Reset asserted mid-frame returns all outputs to their reset values immediately. A pending mode request is discarded.

Optional Feature:
- Macro: VGA_TIMING_CE_EN.
- When defined:
  - Adds input port ce (1 bit).
  - Counters, mode sampling and all registered outputs update only on cycles with ce=1; with ce=0 all outputs hold.
  - frame_start is high only on the ce=1-qualified cycle that produces (0,0).
  - This supports running from a faster system clock with a pixel enable.
- When undefined: no ce port; the block behaves as if ce=1 on every cycle.

Decomposition:
- Package vga_multi_pkg holds:
  - typedef enum for mode (MODE_640x480, MODE_800x600, MODE_1024x768).
  - typedef struct packed for axis timing (visible, front_porch, sync_pulse, full, sync_pol).
  - Constant array of H and V structs indexed by mode.
  - CNT_W default.
- One sub-module, vga_axis_gen, is instantiated twice (H and V). Ports: clk, rst_n, step, timing struct. Outputs: count, sync, blnk, last.
- The top level holds the mode register and the frame-boundary sampling logic.

Test Plan:
- Reset with DEFAULT_MODE=2, run 1344*806 cycles:
  - hsync is low exactly for hcount 1048..1183.
  - vsync is low exactly for vcount 771..776.
  - hblnk rises at hcount 1024; vblnk rises at vcount 768.
  - frame_start fires once, at the second (0,0).
- Set mode_req=0 mid-frame in mode 2:
  - mode_cur stays 2 until the cycle after (1343,805).
  - The next frame has HT=800 and VT=525, hsync low at 656..751, vsync low at 490..491.
- Select mode 1: hsync is high only at hcount 840..967; vsync is high at vcount 601..604; a frame is 1056*628 cycles.
- Hold mode_req=3 across a boundary: mode_cur is unchanged and no timing glitch occurs.
- Assert rst_n low at hcount=500, vcount=300 in mode 1: outputs immediately go to the reset values of DEFAULT_MODE, and the pending request is dropped.
- With VGA_TIMING_CE_EN and ce toggling 1/0: counters advance every other clk, outputs hold during ce=0, and a full mode-2 frame takes 2*1344*806 clks.
